// File: rtl/padring_bist_pkg.sv
// Shared types and constants for the padring loopback BIST.
//   - FSM state encoding (state_t with StIdle/StRun/StDrain/StDone constants)
//   - pattern mode enum (mode_e)
//   - PRBS polynomial x^16+x^14+x^13+x^11+1, derived Fibonacci taps and default seed
//   - lfsr_step(): one right-shift Fibonacci LFSR step
package padring_bist_pkg;

   typedef logic [1:0] state_t;
   localparam state_t StIdle  = 2'd0;
   localparam state_t StRun   = 2'd1;
   localparam state_t StDrain = 2'd2;
   localparam state_t StDone  = 2'd3;

   typedef enum logic [1:0] {
      ModeWalk1   = 2'd0,
      ModeWalk0   = 2'd1,
      ModePrbs    = 2'd2,
      ModeChecker = 2'd3
   } mode_e;

   // Bit k of the polynomial is the x^k term.
   localparam logic [16:0] LfsrPoly        = 17'h1_6801;
   localparam logic [15:0] DefaultPrbsSeed = 16'hACE1;

   // Right-shifting Fibonacci form: term x^k taps state bit 16-k.
   function automatic logic [15:0] taps_from_poly(input logic [16:0] poly);
      logic [15:0] taps;
      for (int i = 0; i < 16; i++) begin
         taps[i] = poly[16-i];
      end
      return taps;
   endfunction

   localparam logic [15:0] LfsrTaps = taps_from_poly(LfsrPoly);

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {^(s & LfsrTaps), s[15:1]};
   endfunction

endpackage

// File: rtl/padring_loopback_bist_if.sv
// Control/status bundle of the padring loopback BIST.
//   start, abort, mode           : run control (master -> slave)
//   busy, done, pass, err_count  : run status  (slave -> master)
//   err_map                      : sticky per-bit error map, only present when
//                                  PADRING_BIST_ERR_MAP_EN is defined
interface padring_loopback_bist_if #(
   parameter int unsigned WIDTH = 12,
   parameter int unsigned ERR_W = 8
);
   logic             start;
   logic             abort;
   logic [1:0]       mode;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_count;
`ifdef PADRING_BIST_ERR_MAP_EN
   logic [WIDTH-1:0] err_map;

   modport master (output start, abort, mode, input busy, done, pass, err_count, err_map);
   modport slave  (input start, abort, mode, output busy, done, pass, err_count, err_map);
`else
   modport master (output start, abort, mode, input busy, done, pass, err_count);
   modport slave  (input start, abort, mode, output busy, done, pass, err_count);
`endif
endinterface

// File: rtl/padring_bist_patgen.sv
// Pattern generator for the padring loopback BIST (purely combinational).
//   mode_i    : pattern select (walk-1, walk-0, PRBS, checker)
//   bit_pos_i : idx mod WIDTH, kept by the caller as a wrapping counter
//   idx_odd_i : LSB of the vector index (checker phase)
//   lfsr_i    : current LFSR state; its low bits form the PRBS vector
//   advance_i : when high, lfsr_o is the stepped state, otherwise lfsr_i
//   vec_o     : vector for the current index
//   lfsr_o    : LFSR state for the next index
module padring_bist_patgen
   import padring_bist_pkg::*;
#(
   parameter int unsigned WIDTH     = 12,
   parameter int unsigned BIT_POS_W = 4
) (
   input  mode_e                mode_i,
   input  logic [BIT_POS_W-1:0] bit_pos_i,
   input  logic                 idx_odd_i,
   input  logic [15:0]          lfsr_i,
   input  logic                 advance_i,
   output logic [WIDTH-1:0]     vec_o,
   output logic [WIDTH-1:0]     unused_o_dummy_never,
   output logic [15:0]          lfsr_o
);

   logic [WIDTH-1:0] one_hot;
   logic [WIDTH-1:0] even_bits;

   assign unused_o_dummy_never = '0;

   always_comb begin
      one_hot   = WIDTH'(1) << bit_pos_i;
      even_bits = '0;
      for (int i = 0; i < WIDTH; i += 2) begin
         even_bits[i] = 1'b1;
      end
   end

   always_comb begin
      vec_o = '0;
      unique case (mode_i)
         ModeWalk1:   vec_o = one_hot;
         ModeWalk0:   vec_o = ~one_hot;
         ModePrbs:    vec_o = WIDTH'(lfsr_i);
         ModeChecker: vec_o = idx_odd_i ? ~even_bits : even_bits;
         default:     vec_o = '0;
      endcase
   end

   assign lfsr_o = advance_i ? lfsr_step(lfsr_i) : lfsr_i;

endmodule

// File: rtl/padring_loopback_bist.sv
// Padring loopback BIST: drives patterns onto uo, synchronizes the looped-back
// ui, and compares each returned vector with its expected value delayed by the
// loop latency LAT = SYNC_STAGES + 1 (output register + synchronizer).
//   clk, rst_n     : clock, synchronous active-low reset
//   ctrl_io        : control/status interface (slave modport)
//   ui_pad2core_i  : returned loopback data, asynchronous to clk
//   uo_core2pad_o  : registered pattern to the output pads
// Optional: define PADRING_BIST_ERR_MAP_EN to add ctrl_io.err_map, a sticky
// per-bit OR of expected^received over valid compares.
module padring_loopback_bist
   import padring_bist_pkg::*;
#(
   parameter int unsigned WIDTH       = 12,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned NUM_VECTORS = 256,
   parameter logic [15:0] PRBS_SEED   = DefaultPrbsSeed,
   parameter int unsigned ERR_W       = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   padring_loopback_bist_if.slave   ctrl_io,
   input  logic [WIDTH-1:0]         ui_pad2core_i,
   output logic [WIDTH-1:0]         uo_core2pad_o
);

   localparam int unsigned LAT       = SYNC_STAGES + 1;
   localparam int unsigned IDX_W     = $clog2(NUM_VECTORS);
   localparam int unsigned BIT_POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned DRAIN_W   = $clog2(LAT + 1);

   state_t               state_q, state_d;
   mode_e                mode_q, mode_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [BIT_POS_W-1:0] bit_pos_q, bit_pos_d;
   logic [15:0]          lfsr_q, lfsr_d;
   logic [DRAIN_W-1:0]   drain_q, drain_d;
   logic [WIDTH-1:0]     uo_q, uo_d;
   logic [ERR_W-1:0]     err_count_q, err_count_d;

   logic [WIDTH-1:0]     sync_q [SYNC_STAGES];
   logic [WIDTH-1:0]     exp_q  [LAT];
   logic [LAT-1:0]       vld_q;

   logic                 start_ok;
   logic                 push;
   logic                 pat_adv;
   logic [WIDTH-1:0]     pat_vec;
   logic [WIDTH-1:0]     pat_spare;
   logic [15:0]          pat_lfsr;
   logic                 cmp_valid;
   logic [WIDTH-1:0]     cmp_diff;

   // Abort wins over start; start only lands when no run is in progress.
   assign start_ok = ctrl_io.start && !ctrl_io.abort &&
                     ((state_q == StIdle) || (state_q == StDone));
   assign pat_adv  = (state_q == StRun);

   padring_bist_patgen #(
      .WIDTH     (WIDTH),
      .BIT_POS_W (BIT_POS_W)
   ) u_patgen (
      .mode_i               (mode_q),
      .bit_pos_i            (bit_pos_q),
      .idx_odd_i            (idx_q[0]),
      .lfsr_i               (lfsr_q),
      .advance_i            (pat_adv),
      .vec_o                (pat_vec),
      .unused_o_dummy_never (pat_spare),
      .lfsr_o               (pat_lfsr)
   );

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      idx_d     = idx_q;
      bit_pos_d = bit_pos_q;
      lfsr_d    = pat_lfsr;
      drain_d   = drain_q;
      uo_d      = '0;
      push      = 1'b0;
      if (ctrl_io.abort) begin
         state_d = StIdle;
      end else if (start_ok) begin
         state_d   = StRun;
         mode_d    = mode_e'(ctrl_io.mode);
         idx_d     = '0;
         bit_pos_d = '0;
         lfsr_d    = PRBS_SEED;
      end else begin
         unique case (state_q)
            StRun: begin
               uo_d      = pat_vec;
               push      = 1'b1;
               idx_d     = idx_q + 1'b1;
               bit_pos_d = (bit_pos_q == BIT_POS_W'(WIDTH - 1)) ? '0 : bit_pos_q + 1'b1;
               if (idx_q == IDX_W'(NUM_VECTORS - 1)) begin
                  state_d = StDrain;
                  drain_d = '0;
               end
            end
            StDrain: begin
               drain_d = drain_q + 1'b1;
               if (drain_q == DRAIN_W'(LAT - 1)) begin
                  state_d = StDone;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         mode_q    <= ModeWalk1;
         idx_q     <= '0;
         bit_pos_q <= '0;
         lfsr_q    <= PRBS_SEED;
         drain_q   <= '0;
         uo_q      <= '0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         idx_q     <= idx_d;
         bit_pos_q <= bit_pos_d;
         lfsr_q    <= lfsr_d;
         drain_q   <= drain_d;
         uo_q      <= uo_d;
      end
   end

   // exp_q[0] loads in step with uo_q, so exp_q[LAT-1] lines up with the last
   // synchronizer stage.
   always_ff @(posedge clk) begin
      if (!rst_n || ctrl_io.abort) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
         for (int i = 0; i < LAT; i++) begin
            exp_q[i] <= '0;
         end
         vld_q <= '0;
      end else begin
         sync_q[0] <= ui_pad2core_i;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
         exp_q[0] <= uo_d;
         for (int i = 1; i < LAT; i++) begin
            exp_q[i] <= exp_q[i-1];
         end
         vld_q <= {vld_q[LAT-2:0], push};
      end
   end

   assign cmp_valid = vld_q[LAT-1];
   assign cmp_diff  = sync_q[SYNC_STAGES-1] ^ exp_q[LAT-1];

   always_comb begin
      err_count_d = err_count_q;
      if (start_ok) begin
         err_count_d = '0;
      end else if (!ctrl_io.abort && cmp_valid && (|cmp_diff) &&
                   (err_count_q != {ERR_W{1'b1}})) begin
         err_count_d = err_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_count_q <= '0;
      end else begin
         err_count_q <= err_count_d;
      end
   end

`ifdef PADRING_BIST_ERR_MAP_EN
   logic [WIDTH-1:0] err_map_q, err_map_d;

   always_comb begin
      err_map_d = err_map_q;
      if (start_ok) begin
         err_map_d = '0;
      end else if (!ctrl_io.abort && cmp_valid) begin
         err_map_d = err_map_q | cmp_diff;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_map_q <= '0;
      end else begin
         err_map_q <= err_map_d;
      end
   end

   assign ctrl_io.err_map = err_map_q;
`endif

   assign ctrl_io.busy      = (state_q == StRun) || (state_q == StDrain);
   assign ctrl_io.done      = (state_q == StDone);
   assign ctrl_io.pass      = (state_q == StDone) && (err_count_q == '0);
   assign ctrl_io.err_count = err_count_q;
   assign uo_core2pad_o     = uo_q;

endmodule

// File: tb/tb_padring_loopback_bist.sv
module tb_padring_loopback_bist;

   localparam int W    = 12;
   localparam int SYNC = 2;
   localparam int NV   = 256;
   localparam int EW   = 8;
   localparam int LAT  = SYNC + 1;

   typedef struct {
      int unsigned     done_edge;
      int unsigned     errs;
      logic            pass;
      logic [W-1:0]    map;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] ui;
   logic [W-1:0] uo;

   int           checks = 0;
   int           errors = 0;
   int unsigned  edge_cnt = 0;
   int           fault_kind = 0;
   int           fault_a = 0;
   int           fault_b = 0;
   int unsigned  last_errs = 0;
   logic         done_prev = 1'b0;
   exp_t         sb[$];
   exp_t         mon_e;
   logic [W-1:0] model_vecs [NV];

   padring_loopback_bist_if #(.WIDTH(W), .ERR_W(EW)) bus ();

   padring_loopback_bist #(
      .WIDTH       (W),
      .SYNC_STAGES (SYNC),
      .NUM_VECTORS (NV),
      .PRBS_SEED   (16'hACE1),
      .ERR_W       (EW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ctrl_io       (bus),
      .ui_pad2core_i (ui),
      .uo_core2pad_o (uo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   // 0 none, 1 stuck-at-0 a, 2 stuck-at-1 a, 3 invert a, 4 wired-AND short a/b
   function automatic logic [W-1:0] apply_fault(input logic [W-1:0] v, input int k,
                                                input int a, input int b);
      logic [W-1:0] r;
      r = v;
      case (k)
         1: r[a] = 1'b0;
         2: r[a] = 1'b1;
         3: r[a] = ~v[a];
         4: begin
            r[a] = v[a] & v[b];
            r[b] = v[a] & v[b];
         end
         default: ;
      endcase
      return r;
   endfunction

   always_comb ui = apply_fault(uo, fault_kind, fault_a, fault_b);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic build_model(input int mode);
      logic [15:0] s;
      logic [W-1:0] v;
      s = 16'hACE1;
      for (int idx = 0; idx < NV; idx++) begin
         v = '0;
         case (mode)
            0: v = W'(1) << (idx % W);
            1: v = ~(W'(1) << (idx % W));
            2: begin
               v = s[W-1:0];
               s = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
            end
            default: begin
               for (int b = 0; b < W; b++) v[b] = ((b % 2) == (idx % 2));
            end
         endcase
         model_vecs[idx] = v;
      end
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!bus.done && n < NV + LAT + 60) begin
         @(negedge clk);
         n++;
      end
      check("done_reached", 32'(bus.done), 32'd1);
   endtask

   task automatic run(input int mode, input int fk, input int fa, input int fb, input bit poke);
      exp_t e;
      logic [W-1:0] f;
      int unsigned cnt;
      fault_kind = fk;
      fault_a    = fa;
      fault_b    = fb;
      build_model(mode);
      cnt   = 0;
      e.map = '0;
      for (int i = 0; i < NV; i++) begin
         f = apply_fault(model_vecs[i], fk, fa, fb);
         if (f != model_vecs[i]) cnt++;
         e.map |= f ^ model_vecs[i];
      end
      e.errs = (cnt > 255) ? 255 : cnt;
      e.pass = (cnt == 0);
      @(negedge clk);
      bus.mode  = 2'(mode);
      bus.start = 1'b1;
      // start lands on the next edge; done is visible NV+LAT edges after it
      e.done_edge = edge_cnt + 1 + NV + LAT;
      sb.push_back(e);
      last_errs = e.errs;
      @(negedge clk);
      bus.start = 1'b0;
      if (poke) begin
         repeat (40) @(negedge clk);
         bus.start = 1'b1;
         bus.mode  = 2'($urandom_range(0, 3));
         @(negedge clk);
         bus.start = 1'b0;
      end
      wait_done();
   endtask

   // Scoreboard monitor: each rising done retires one expected run result.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && bus.done && !done_prev) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               mon_e = sb.pop_front();
               check("done_edge", edge_cnt, mon_e.done_edge);
               check("err_count", 32'(bus.err_count), mon_e.errs);
               check("pass", 32'(bus.pass), 32'(mon_e.pass));
               check("uo_in_done", 32'(uo), 32'd0);
`ifdef PADRING_BIST_ERR_MAP_EN
               check("err_map", 32'(bus.err_map), 32'(mon_e.map));
`endif
            end
         end
         done_prev = rst_n ? bus.done : 1'b0;
      end
   end

   task automatic check_idle(input string tag, input int unsigned errs);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_done"}, 32'(bus.done), 32'd0);
      check({tag, "_pass"}, 32'(bus.pass), 32'd0);
      check({tag, "_uo"}, 32'(uo), 32'd0);
      check({tag, "_err_count"}, 32'(bus.err_count), errs);
   endtask

   initial begin
      int fk;
      int fa;
      int fb;
      int wait_n;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.mode  = 2'd0;
      rst_n     = 1'b0;
      repeat (3) @(negedge clk);
      check_idle("reset", 0);
`ifdef PADRING_BIST_ERR_MAP_EN
      check("reset_err_map", 32'(bus.err_map), 32'd0);
`endif
      rst_n = 1'b1;

      // Directed cases: ideal, stuck bit 5, inverted PRBS bit 0, shorted 3/4.
      run(0, 0, 0, 0, 1'b0);
      repeat (4) @(negedge clk);
      check("done_level", 32'(bus.done), 32'd1);
      run(0, 1, 5, 0, 1'b0);
      run(2, 3, 0, 0, 1'b0);
      run(3, 4, 3, 4, 1'b0);

      // Abort part-way through RUN.
      fault_kind = 0;
      @(negedge clk);
      bus.mode  = 2'd0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (99) @(negedge clk);
      bus.abort = 1'b1;
      @(negedge clk);
      check_idle("abort", 0);
      bus.abort = 1'b0;
      run(0, 0, 0, 0, 1'b0);

      // Start poked during RUN is ignored; then start+abort in DONE goes idle.
      run(0, 1, 5, 0, 1'b1);
      @(negedge clk);
      bus.start = 1'b1;
      bus.abort = 1'b1;
      @(negedge clk);
      check_idle("start_abort", last_errs);
      bus.start = 1'b0;
      bus.abort = 1'b0;
      repeat (3) @(negedge clk);
      check("start_abort_stay_idle", 32'(bus.busy), 32'd0);

      // Reset in the middle of a faulty run.
      fault_kind = 2;
      fault_a    = 2;
      @(negedge clk);
      bus.mode  = 2'd2;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (60) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check_idle("midrun_reset", 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Randomized runs against the reference model.
      for (int r = 0; r < 8; r++) begin
         fk = int'($urandom_range(0, 4));
         fa = int'($urandom_range(0, W - 1));
         fb = (fa + 1 + int'($urandom_range(0, W - 2))) % W;
         run(int'($urandom_range(0, 3)), fk, fa, fb, 1'($urandom_range(0, 1)));
      end

      wait_n = 0;
      while (sb.size() != 0 && wait_n < 20) begin
         @(negedge clk);
         wait_n++;
      end
      check("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
